// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared encodings and default vectors for the PC sequencer
package pc_sequencer_pkg;
  typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_BR = 2'b01, PC_J = 2'b10, PC_JR = 2'b11} pc_src_e;
  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;
endpackage

// File: rtl/pc_target_mux.sv
// pc_target_mux: next-PC source selection, aligned target and misalignment flag
module pc_target_mux
  import pc_sequencer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ALIGN_BITS = 2,
  parameter int JBITS      = 26
) (
  input  logic [WIDTH-1:0] i_pc,
  input  logic [1:0]       i_pc_src,
  input  logic [WIDTH-1:0] i_imm_ext,
  input  logic [JBITS-1:0] i_jaddr,
  input  logic [WIDTH-1:0] i_rs_data,
  output logic [WIDTH-1:0] o_pc4,
  output logic [WIDTH-1:0] o_target,
  output logic             o_misalign
);
  localparam logic [WIDTH-1:0] INC = WIDTH'(1) << ALIGN_BITS;
  logic [WIDTH-1:0] w_raw;
  assign o_pc4 = i_pc + INC;
  // Jumps keep the region bits of PC4 above the jump field.
  assign w_raw = i_pc_src == PC_SEQ ? o_pc4 :
                 i_pc_src == PC_BR  ? o_pc4 + (i_imm_ext << ALIGN_BITS) :
                 i_pc_src == PC_J   ? {o_pc4[WIDTH-1:JBITS+ALIGN_BITS], i_jaddr, {ALIGN_BITS{1'b0}}} :
                                      i_rs_data;
  assign o_target   = {w_raw[WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
  assign o_misalign = |w_raw[ALIGN_BITS-1:0];
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered PC with branch/jump selection, exception redirect
// with EPC capture, halt/resume control and misaligned-target pulse.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              WIDTH      = 32,
  parameter int              ALIGN_BITS = 2,
  parameter int              JBITS      = 26,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic [JBITS-1:0] jaddr,
  input  logic [WIDTH-1:0] rs_data,
  input  logic             exc,
  input  logic             halt_req,
  input  logic             resume,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC4,
  output logic [WIDTH-1:0] EPC,
  output logic             halted,
  output logic             misalign
);
  logic [WIDTH-1:0] r_pc, r_epc, w_target;
  logic             r_misalign, w_misalign;
  state_e           r_state;

  pc_target_mux #(.WIDTH(WIDTH), .ALIGN_BITS(ALIGN_BITS), .JBITS(JBITS)) u_mux (
    .i_pc(r_pc), .i_pc_src(PCSrc), .i_imm_ext(imm_ext), .i_jaddr(jaddr),
    .i_rs_data(rs_data), .o_pc4(PC4), .o_target(w_target), .o_misalign(w_misalign)
  );

  // In RUN: exception beats halt request beats PC write.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_pc       <= RESET_PC;
      r_epc      <= '0;
      r_state    <= ST_RUN;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (r_state == ST_RUN) begin
        if (exc) begin
          r_epc <= r_pc;
          r_pc  <= EXC_VECTOR;
        end else if (halt_req) begin
          r_state <= ST_HALT;
        end else if (PCWre) begin
          r_pc       <= w_target;
          r_misalign <= w_misalign;
        end
      end else if (resume && !halt_req) begin
        r_state <= ST_RUN;
      end
    end
  end

  assign PC       = r_pc;
  assign EPC      = r_epc;
  assign halted   = r_state == ST_HALT;
  assign misalign = r_misalign;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a behavioural model
module tb_pc_sequencer;
  logic        CLK = 0, Reset = 1, PCWre = 0, exc = 0, halt_req = 0, resume = 0;
  logic [1:0]  PCSrc = 0;
  logic [31:0] imm_ext = 0, rs_data = 0;
  logic [25:0] jaddr = 0;
  logic [31:0] PC, PC4, EPC;
  logic        halted, misalign;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] m_pc = 0, m_epc = 0;
  bit          m_h = 0, m_mis = 0;

  pc_sequencer dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .imm_ext(imm_ext),
    .jaddr(jaddr), .rs_data(rs_data), .exc(exc), .halt_req(halt_req), .resume(resume),
    .PC(PC), .PC4(PC4), .EPC(EPC), .halted(halted), .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input bit we, input logic [1:0] src, input logic [31:0] imm,
                       input logic [25:0] ja, input logic [31:0] rs, input bit ex, input bit hr, input bit rsm);
    Reset = 0; PCWre = we; PCSrc = src; imm_ext = imm; jaddr = ja; rs_data = rs;
    exc = ex; halt_req = hr; resume = rsm;
  endtask

  // Model: next state from the current inputs using byte-address arithmetic mod 2^32.
  task automatic cyc();
    longint mask = 64'hFFFF_FFFF;
    longint pc4, t;
    logic [31:0] npc = m_pc, nepc = m_epc;
    bit nh = m_h, nm = 0;
    pc4 = (longint'(m_pc) + 4) & mask;
    case (PCSrc)
      2'd0: t = pc4;
      2'd1: t = (pc4 + longint'($signed(imm_ext)) * 4) & mask;
      2'd2: t = (pc4 / 64'h1000_0000) * 64'h1000_0000 + longint'(jaddr) * 4;
      default: t = longint'(rs_data);
    endcase
    if (Reset) begin
      npc = 32'h0; nepc = 0; nh = 0;
    end else if (m_h) begin
      if (resume && !halt_req) nh = 0;
    end else if (exc) begin
      nepc = m_pc; npc = 32'h80;
    end else if (halt_req) begin
      nh = 1;
    end else if (PCWre) begin
      npc = 32'(t - t % 4); nm = (t % 4) != 0;
    end
    @(posedge CLK); #1;
    m_pc = npc; m_epc = nepc; m_h = nh; m_mis = nm;
  endtask

  task automatic test_reset();
    Reset = 1; cyc(); cyc();
    n_cmp++; if (PC !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want %h", PC, 32'h0); end
    n_cmp++; if (PC4 !== 32'h4) begin n_bad++; $display("FAIL reset_pc4 got %h want %h", PC4, 32'h4); end
    n_cmp++; if (EPC !== 32'h0) begin n_bad++; $display("FAIL reset_epc got %h want %h", EPC, 32'h0); end
    n_cmp++; if ({halted, misalign} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {halted, misalign}); end
  endtask

  task automatic test_seq();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 2'd0, 0, 0, 0, 0, 0, 0); cyc();
      n_cmp++; if (PC !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_pc%0d got %h want %h", i, PC, 32'(4 * i)); end
      n_cmp++; if (PC4 !== 32'(4 * i + 4)) begin n_bad++; $display("FAIL seq_pc4_%0d got %h want %h", i, PC4, 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_branch_jump();
    drive(1, 2'd3, 0, 0, 32'h100, 0, 0, 0); cyc();
    drive(1, 2'd1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0); cyc();
    n_cmp++; if (PC !== 32'hFC) begin n_bad++; $display("FAIL branch_pc got %h want %h", PC, 32'hFC); end
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL branch_mis got %b want 0", misalign); end
    drive(1, 2'd2, 0, 26'h40, 0, 0, 0, 0); cyc();
    n_cmp++; if (PC !== 32'h100) begin n_bad++; $display("FAIL jump_pc got %h want %h", PC, 32'h100); end
  endtask

  task automatic test_misalign();
    drive(1, 2'd3, 0, 0, 32'h200, 0, 0, 0); cyc();
    drive(1, 2'd3, 0, 0, 32'h1003, 0, 0, 0); cyc();
    n_cmp++; if (PC !== 32'h1000) begin n_bad++; $display("FAIL mis_pc got %h want %h", PC, 32'h1000); end
    n_cmp++; if (misalign !== 1'b1) begin n_bad++; $display("FAIL mis_pulse got %b want 1", misalign); end
    drive(0, 2'd3, 0, 0, 32'h1003, 0, 0, 0); cyc();
    n_cmp++; if (misalign !== 1'b0) begin n_bad++; $display("FAIL mis_clear got %b want 0", misalign); end
    n_cmp++; if (PC !== 32'h1000) begin n_bad++; $display("FAIL mis_hold got %h want %h", PC, 32'h1000); end
  endtask

  task automatic test_exc_priority();
    drive(1, 2'd3, 0, 0, 32'h300, 0, 0, 0); cyc();
    drive(1, 2'd3, 0, 0, 32'h555, 1, 1, 0); cyc();
    n_cmp++; if (EPC !== 32'h300) begin n_bad++; $display("FAIL exc_epc got %h want %h", EPC, 32'h300); end
    n_cmp++; if (PC !== 32'h80) begin n_bad++; $display("FAIL exc_pc got %h want %h", PC, 32'h80); end
    n_cmp++; if ({halted, misalign} !== 2'b00) begin n_bad++; $display("FAIL exc_flags got %b want 00", {halted, misalign}); end
  endtask

  task automatic test_halt();
    drive(1, 2'd0, 0, 0, 0, 0, 1, 0); cyc();
    n_cmp++; if (halted !== 1'b1 || PC !== 32'h80) begin n_bad++; $display("FAIL halt_enter got h=%b pc=%h want h=1 pc=80", halted, PC); end
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'd3, 0, 0, 32'h4003, i % 2, 0, 0); cyc();
      n_cmp++; if (halted !== 1'b1 || PC !== 32'h80 || EPC !== 32'h300 || misalign !== 1'b0)
        begin n_bad++; $display("FAIL halt_hold%0d got h=%b pc=%h epc=%h m=%b want h=1 pc=80 epc=300 m=0", i, halted, PC, EPC, misalign); end
    end
    drive(1, 2'd0, 0, 0, 0, 0, 1, 1); cyc();
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_both got %b want 1", halted); end
    drive(1, 2'd0, 0, 0, 0, 0, 0, 1); cyc();
    n_cmp++; if (halted !== 1'b0 || PC !== 32'h80) begin n_bad++; $display("FAIL resume got h=%b pc=%h want h=0 pc=80", halted, PC); end
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0); cyc();
    n_cmp++; if (PC !== 32'h84) begin n_bad++; $display("FAIL post_resume got %h want %h", PC, 32'h84); end
  endtask

  task automatic test_wrap_reset_halt();
    drive(1, 2'd3, 0, 0, 32'hFFFF_FFFC, 0, 0, 0); cyc();
    n_cmp++; if (PC4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4 got %h want 0", PC4); end
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0); cyc();
    n_cmp++; if (PC !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got %h want 0", PC); end
    drive(0, 2'd0, 0, 0, 0, 0, 1, 0); cyc();
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL wrap_halt got %b want 1", halted); end
    Reset = 1; cyc(); Reset = 0;
    n_cmp++; if (PC !== 32'h0 || halted !== 1'b0 || EPC !== 32'h0)
      begin n_bad++; $display("FAIL reset_halted got pc=%h h=%b epc=%h want 0/0/0", PC, halted, EPC); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3, 0) != 0, 2'($urandom), 32'($signed(7'($urandom))),
            26'($urandom), $urandom, $urandom_range(15, 0) == 0, $urandom_range(9, 0) == 0,
            $urandom_range(3, 0) == 0);
      Reset = $urandom_range(63, 0) == 0;
      cyc();
      n_cmp++; if (PC !== m_pc || PC4 !== m_pc + 32'd4 || EPC !== m_epc || halted !== m_h || misalign !== m_mis)
        begin n_bad++; $display("FAIL rand%0d got pc=%h pc4=%h epc=%h h=%b m=%b want pc=%h pc4=%h epc=%h h=%b m=%b",
          i, PC, PC4, EPC, halted, misalign, m_pc, m_pc + 32'd4, m_epc, m_h, m_mis); end
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch_jump();
    test_misalign();
    test_exc_priority();
    test_halt();
    test_wrap_reset_halt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the multicycle CPU. It replaces the bare combinational PC+4 adder with a registered PC. The unit selects the next PC from four sources: sequential, PC-relative branch, absolute jump, or register jump. It also provides an exception redirect with EPC capture, a halt/resume state machine and misaligned-target detection. It sits between the control unit (PCWre, PCSrc) and instruction memory (PC).

Parameters:
WIDTH, 32, PC/datapath width in bits (must be >= JBITS+ALIGN_BITS+1)
ALIGN_BITS, 2, log2 of instruction size in bytes; increment = 1<<ALIGN_BITS
JBITS, 26, width of the absolute-jump address field
RESET_PC, 32'h0000_0000, PC value loaded on reset
EXC_VECTOR, 32'h0000_0080, PC value loaded on exception

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
PCWre  in  1  PC write enable from the control unit
PCSrc  in  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 register
imm_ext  in  WIDTH  sign-extended branch offset, in instructions
jaddr  in  JBITS  jump target field, in instructions
rs_data  in  WIDTH  register jump target, byte address
exc  in  1  exception request
halt_req  in  1  enter HALTED state
resume  in  1  leave HALTED state
PC  out  WIDTH  current PC (registered)
PC4  out  WIDTH  PC + (1<<ALIGN_BITS) (combinational from PC)
EPC  out  WIDTH  PC captured at the last exception (registered)
halted  out  1  1 while in HALTED state
misalign  out  1  one-cycle pulse: last loaded target was misaligned

Behaviour:
- One clock (CLK). Reset is synchronous and active-high. All state updates occur on the rising edge of CLK.
- Reset values: PC=RESET_PC, EPC=0, halted=0, misalign=0, state=RUN. Reset takes priority over every other input.
- Arithmetic is modulo 2^WIDTH with silent wrap: PC4 = PC + (1<<ALIGN_BITS), so all-ones-aligned + increment wraps to 0.
- Target selection (combinational):
  - seq = PC4
  - branch = PC4 + (imm_ext << ALIGN_BITS)
  - jump = {PC4[WIDTH-1:JBITS+ALIGN_BITS], jaddr, ALIGN_BITS zeros}
  - register = rs_data
- States: RUN, HALTED. halted = (state==HALTED).
- Per-edge priority in RUN: exc > halt_req > PCWre.
  - exc=1: EPC<=PC, PC<=EXC_VECTOR, misalign<=0. PCWre and halt_req are ignored that cycle.
  - else halt_req=1: state<=HALTED, PC held, even if PCWre=1.
  - else PCWre=1: PC<=target with the low ALIGN_BITS forced to 0. misalign<=1 if the selected target's low ALIGN_BITS were nonzero, else 0.
  - else: PC held, misalign<=0.
- HALTED:
  - PC and EPC are held. PCWre and exc are ignored. misalign<=0.
  - resume=1 moves state to RUN at the next edge. No PC update occurs on the resume edge.
  - halt_req and resume both high: stay in HALTED.
- misalign is only ever a one-cycle registered pulse. Only PCSrc=11 can produce it (the other sources are aligned by construction).
- Latency: a PCWre asserted in cycle n makes the new PC visible in cycle n+1. PC4 follows PC in the same cycle.
- Reset mid-halt or mid-exception returns the unit to RUN at RESET_PC with EPC=0.

Decomposition:
- Shared package holds:
  - PCSrc encodings: PC_SEQ=2'b00, PC_BR=2'b01, PC_J=2'b10, PC_JR=2'b11
  - state encoding: ST_RUN=1'b0, ST_HALT=1'b1
  - default RESET_PC and EXC_VECTOR constants
- One combinational sub-module, pc_target_mux, computes PC4, the selected target and the raw misalign flag. The top level holds the registers and the FSM.

Test Plan:
- Reset asserted, then 3 cycles of PCWre=1, PCSrc=00 -> PC 0x0, 0x4, 0x8, 0xC. PC4 always equals PC+4.
- PC=0x100, PCSrc=01, imm_ext=0xFFFF_FFFE, PCWre=1 -> PC=0xFC. Then jaddr=0x000_0040, PCSrc=10 -> PC=0x100.
- PC=0x200, PCSrc=11, rs_data=0x0000_1003, PCWre=1 -> PC=0x1000 and misalign=1 for exactly one cycle, then 0.
- PC=0x300, exc=1, halt_req=1, PCWre=1 in the same cycle -> EPC=0x300, PC=0x80, halted=0.
- halt_req=1 with PCWre=1 -> PC frozen. halted=1 for 5 cycles of PCWre=1. resume=1 -> halted=0 next cycle, PC unchanged. Next PCWre advances PC by 4.
- PC=0xFFFF_FFFC, PCSrc=00, PCWre=1 -> PC=0x0000_0000. Reset asserted while halted -> PC=RESET_PC, halted=0, EPC=0.
